// File: rtl/rr_decoder_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_decoder_arbiter_if
//   Bundles the request side and the decoded-grant side of the round-robin
//   decoder arbiter.
//
//   Signals:
//     arb_en  : 1 = new grants may be issued
//     req     : [7:0] request vector, req[i] held high while requester i
//               needs the shared resource
//     sel     : [2:0] registered index of the current owner (decoder A)
//     en      : registered grant-valid (decoder E)
//     gnt     : [7:0] one-hot decoded grant
//     busy    : high while a grant is active
//     timeout : one-cycle pulse after a forced release
//
//   Modports:
//     master : requester side (drives arb_en/req)
//     slave  : arbiter side (drives sel/en/gnt/busy/timeout)
// ---------------------------------------------------------------------------
interface rr_decoder_arbiter_if;
    logic       arb_en;
    logic [7:0] req;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (
        output arb_en, req,
        input  sel, en, gnt, busy, timeout
    );

    modport slave (
        input  arb_en, req,
        output sel, en, gnt, busy, timeout
    );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decoder_arbiter
//   Round-robin arbiter that shares one 3-to-8 decoded resource among eight
//   requesters. The owner index and enable are registered and fed to a
//   3-to-8 decoder, whose one-hot output is the grant. An owner keeps the
//   resource until it drops its request or, if MAX_HOLD is non-zero, until
//   it has held it for MAX_HOLD cycles. Every release is followed by at
//   least one idle cycle so decoder outputs never overlap.
//
//   Parameters:
//     MAX_HOLD : maximum consecutive grant cycles per owner, 0 = no timeout
//     CNT_W    : hold counter width, MAX_HOLD must be below 2**CNT_W
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : rr_decoder_arbiter_if.slave (arb_en, req in; sel, en, gnt,
//             busy, timeout out)
// ---------------------------------------------------------------------------
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_decoder_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    logic [0:0]       state;
    logic [2:0]       sel_q;
    logic             en_q;
    logic             timeout_q;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [7:0]       req_rot;
    logic [2:0]       offset;
    logic [2:0]       winner;
    logic             timeout_hit;
    logic [7:0]       gnt_dec;

    // Rotate the request vector so that bit 0 is the ptr position; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign req_rot = (bus.req >> ptr) | (bus.req << (4'd8 - {1'b0, ptr}));

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        offset = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = 3'(i);
            end
        end
    end

    assign winner      = ptr + offset;
    assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == MAX_HOLD_C);

    // NOTE: every register here is reset asynchronously so en/gnt drop the
    // moment rst_n falls, even in the middle of a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= 3'd0;
            en_q      <= 1'b0;
            timeout_q <= 1'b0;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples
            // the pre-edge values regardless of statement order.
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.arb_en && (bus.req != 8'h00)) begin
                        state    <= ST_GRANT;
                        sel_q    <= winner;
                        en_q     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (!bus.req[sel_q] || timeout_hit) begin
                        // Voluntary or forced release; the owner drops to
                        // lowest priority and the next cycle is a dead cycle.
                        state     <= ST_IDLE;
                        en_q      <= 1'b0;
                        ptr       <= sel_q + 3'd1;
                        hold_cnt  <= '0;
                        timeout_q <= bus.req[sel_q];
                    end else if (hold_cnt < MAX_HOLD_C) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    en_q  <= 1'b0;
                end
            endcase
        end
    end

    // 3-to-8 decoder driven by the registered select and enable.
    always_comb begin
        gnt_dec = 8'h00;
        if (en_q) begin
            gnt_dec[sel_q] = 1'b1;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.en      = en_q;
    assign bus.gnt     = gnt_dec;
    assign bus.busy    = (state == ST_GRANT);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_decoder_arbiter
//   Scoreboard bench for rr_decoder_arbiter. The stimulus process drives
//   req/arb_en on the falling edge, advances a behavioural model of the
//   arbitration rules and queues the outputs expected after the next rising
//   edge. A monitor pops one entry per rising edge and compares.
// ---------------------------------------------------------------------------
module tb_rr_decoder_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_decoder_arbiter_if bus ();

    rr_decoder_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic [7:0] gnt;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: owner index (-1 = nobody), highest-priority index,
    // cycles held so far, last granted index and the timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_sel   = 0;
    bit m_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic a);
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (a && r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int i;
                    i = (m_ptr + k) % 8;
                    if (m_owner < 0 && r[i]) begin
                        m_owner = i;
                        m_sel   = i;
                        m_hold  = 1;
                    end
                end
            end
        end else if (!r[m_owner] || (MAX_HOLD != 0 && m_hold == MAX_HOLD)) begin
            m_to    = r[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_hold  = 0;
        end else if (m_hold < MAX_HOLD) begin
            m_hold++;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.en      = (m_owner >= 0);
        e.sel     = 3'(m_sel);
        e.gnt     = e.en ? (8'h01 << m_sel) : 8'h00;
        e.busy    = e.en;
        e.timeout = m_to;
        return e;
    endfunction

    task automatic drive(input logic [7:0] r, input logic a);
        bus.req    = r;
        bus.arb_en = a;
        model_step(r, a);
        exp_q.push_back(model_out());
    endtask

    task automatic step(input logic [7:0] r, input logic a);
        @(negedge clk);
        drive(r, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},     bus.sel,     0);
        check({tag, "_en"},      bus.en,      0);
        check({tag, "_gnt"},     bus.gnt,     0);
        check({tag, "_busy"},    bus.busy,    0);
        check({tag, "_timeout"}, bus.timeout, 0);
    endtask

    // Pulse reset between edges, check the outputs collapse at once, then
    // present the next inputs for the following rising edge.
    task automatic reset_pulse(input logic [7:0] r, input logic a);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        #1 rst_n = 1'b1;
        model_reset();
        drive(r, a);
    endtask

    // Requests stay high except that the current owner drops its bit once
    // it has held the grant for 'hold_len' cycles.
    task automatic reactive(input logic [7:0] base, input int hold_len, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            logic [7:0] r;
            @(negedge clk);
            r = base;
            if (m_owner >= 0 && m_hold >= hold_len) begin
                r[m_owner] = 1'b0;
            end
            drive(r, 1'b1);
        end
    endtask

    task automatic wait_owner(input logic [7:0] r, input int idx);
        for (int c = 0; c < 12 && m_owner != idx; c++) begin
            step(r, 1'b1);
        end
    endtask

    // Monitor: one expected entry per rising edge once stimulus is running.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sel",     bus.sel,     e.sel);
                check("en",      bus.en,      e.en);
                check("gnt",     bus.gnt,     e.gnt);
                check("busy",    bus.busy,    e.busy);
                check("timeout", bus.timeout, e.timeout);
            end
        end
    end

    initial begin
        logic [7:0] cur_req;

        bus.req    = 8'hFF;
        bus.arb_en = 1'b0;
        rst_n      = 1'b0;

        // Reset with every request asserted: outputs stay quiet.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        model_reset();
        drive(8'hFF, 1'b0);

        // Arbitration disabled: no grant despite requests.
        repeat (3) step(8'hFF, 1'b0);

        // Single requester 2 for four cycles, then released.
        repeat (4) step(8'h04, 1'b1);
        repeat (3) step(8'h00, 1'b1);

        // Round robin from ptr 0 with every requester active.
        reset_pulse(8'h00, 1'b1);
        reactive(8'hFF, 2, 30);
        repeat (2) step(8'h00, 1'b1);

        // Wrap-around priority: release index 5 so ptr is 6, then 7,0,1.
        wait_owner(8'h20, 5);
        step(8'h00, 1'b1);
        reactive(8'h83, 1, 12);
        repeat (2) step(8'h00, 1'b1);

        // Timeout with a sole requester holding req high.
        repeat (14) step(8'h10, 1'b1);
        repeat (2) step(8'h00, 1'b1);

        // Reset in the middle of a grant to index 5; index 0 wins afterwards.
        wait_owner(8'h20, 5);
        step(8'h20, 1'b1);
        reset_pulse(8'h21, 1'b1);
        repeat (4) step(8'h21, 1'b1);
        repeat (2) step(8'h00, 1'b1);

        // Randomised traffic with sticky requests and occasional resets.
        cur_req = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_pulse(cur_req, 1'b1);
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    cur_req = cur_req ^ 8'($urandom_range(0, 255));
                end
                if (m_owner >= 0 && $urandom_range(0, 2) == 0) begin
                    cur_req[m_owner] = 1'b0;
                end
                step(cur_req, ($urandom_range(0, 7) != 0));
            end
        end

        repeat (3) step(8'h00, 1'b1);
        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter sharing one 3-to-8 decoded resource (select lines plus enable) among 8 requesters.
- Picks one requester, drives a registered 3-bit index and enable into the team's 3-to-8 decoder, and returns the decoded one-hot grant.
- Supports a hold-until-release handshake, an optional hold timeout and a global arbitration enable.
- Sits between requesting blocks and the shared decoded bus/chip-select fabric.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per owner (1..255); 0 disables the timeout.
- CNT_W, 8, width of the hold counter; MAX_HOLD must be less than 2**CNT_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- arb_en  input  1  1 = new grants allowed; 0 = no new grant issued (current grant unaffected)
- req  input  8  request vector; req[i] is held high by requester i for as long as it needs the resource
- sel  output  3  registered index of current owner (decoder A input)
- en  output  1  registered grant-valid (decoder E input)
- gnt  output  8  one-hot grant, decoded from sel/en by the 3-to-8 decoder
- busy  output  1  1 while state is GRANT
- timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=IDLE, sel=0, en=0, gnt=0, busy=0, timeout=0.
  - ptr=0 (ptr is the index with highest priority), hold_cnt=0.
- Invariant at all times: gnt == (en ? 8'b1<<sel : 8'b0). busy == en.
- IDLE:
  - If arb_en=1 and req!=0, select winner = first i with req[i]=1, searching ptr, ptr+1, ... ,7, 0, ... modulo 8.
  - Next edge: sel=winner, en=1, hold_cnt=1, state=GRANT.
  - Grant latency is 1 cycle from req sampled high to gnt high.
  - Otherwise stay in IDLE with en=0. sel keeps its last value.
- GRANT:
  - Release when req[sel]=0 at the edge. Next cycle: en=0, ptr=(sel+1) mod 8, state=IDLE, hold_cnt=0.
  - Forced release when MAX_HOLD!=0, hold_cnt==MAX_HOLD and req[sel]=1. Same transition as release, plus timeout=1 for that one cycle.
  - Otherwise hold_cnt increments, saturating at MAX_HOLD. sel and en are unchanged.
  - Requests from other indices are ignored while in GRANT.
  - arb_en has no effect in GRANT.
- Dead cycle:
  - Every release is followed by at least one cycle with en=0 (IDLE) before the next grant.
  - Minimum gap between two grants is therefore 1 cycle. This is required so the decoder outputs never overlap.
- Fairness:
  - A released owner becomes lowest priority.
  - Ptr is updated only on release or forced release, never in IDLE.
- Simultaneous events:
  - Release and new requests arriving in the same cycle: release is honoured first. The new requests are arbitrated in the following IDLE cycle using the updated ptr.
  - A timed-out owner that keeps req high is re-granted only when its round-robin turn comes again (immediately if it is the sole requester, after the dead cycle).
- Wrap-around: ptr after releasing index 7 is 0.
- Reset mid-grant: en and gnt drop asynchronously to 0, and ptr returns to 0.

Test Plan:
- Reset then idle: rst_n=0 with req=8'hFF; release rst_n, arb_en=0 for 3 cycles -> en=0, gnt=8'h00, busy=0 throughout.
- Single request: arb_en=1, req=8'b0000_0100 held 4 cycles then dropped -> 1 cycle later sel=3'd2, en=1, gnt=8'b0000_0100 for 4 cycles; then gnt=0 for at least 1 cycle; ptr=3.
- Round robin: req=8'hFF, each owner drops req for 1 cycle after 2 grant cycles -> grant order 0,1,2,...,7,0, with exactly one gnt=0 cycle between owners.
- Wrap priority: ptr=6 (after index 5 released), req=8'b1000_0011 -> grant index 7, then 0, then 1.
- Timeout: MAX_HOLD=4, req=8'b0001_0000 held high -> gnt=8'h10 for exactly 4 cycles, timeout=1 for one cycle, gnt=0 for 1 cycle, then re-grant index 4.
- Async reset mid-grant: grant index 5 active, pulse rst_n low between edges -> gnt=0 and en=0 immediately; after release with req=8'b0010_0001, index 0 is granted first (ptr=0).
